// File: rtl/munoc_fni_link_packetizer.sv
// rtl/munoc_fni_link_packetizer.sv - FNI link transmit packetizer (header + body beats to phits); define MUNOC_FNI_TX_STALL_COUNT_EN for stall_count
`timescale 1ns/1ps
module munoc_fni_link_packetizer #(
    parameter int BW_PHIT         = 8,
    parameter int NUM_HEADER_PHIT = 4,
    parameter int NUM_BODY_PHIT   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               hdr_valid,
    output logic                               hdr_ready,
    input  logic [NUM_HEADER_PHIT*BW_PHIT-1:0] hdr_data,
    input  logic                               hdr_has_body,
    input  logic                               body_valid,
    output logic                               body_ready,
    input  logic [NUM_BODY_PHIT*BW_PHIT-1:0]   body_data,
    input  logic                               body_last,
    output logic [BW_PHIT+2:0]                 link_out,
    input  logic                               link_ready
`ifdef MUNOC_FNI_TX_STALL_COUNT_EN
    ,
    output logic [15:0]                        stall_count
`endif
);

    localparam int HDR_W    = NUM_HEADER_PHIT * BW_PHIT;
    localparam int BODY_W   = NUM_BODY_PHIT * BW_PHIT;
    localparam int MAX_PHIT = (NUM_HEADER_PHIT > NUM_BODY_PHIT) ? NUM_HEADER_PHIT : NUM_BODY_PHIT;
    localparam int SR_W     = MAX_PHIT * BW_PHIT;
    localparam int CNT_W    = (MAX_PHIT > 1) ? $clog2(MAX_PHIT) : 1;

    localparam logic [CNT_W-1:0] HDR_LAST_CNT  = CNT_W'(NUM_HEADER_PHIT - 1);
    localparam logic [CNT_W-1:0] BODY_LAST_CNT = CNT_W'(NUM_BODY_PHIT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             valid_q, valid_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             has_body_q, has_body_d;
    logic             body_last_q, body_last_d;

    logic unit_last;
    logic pkt_last;
    logic finish;
    logic hdr_fire;
    logic body_fire;

    // Unit/packet end flags, handshakes and the link word; the unit type follows the state
    always_comb begin
        if (state_q == ST_HDR) begin
            unit_last = valid_q & (cnt_q == HDR_LAST_CNT);
            pkt_last  = unit_last & ~has_body_q;
        end else begin
            unit_last = valid_q & (cnt_q == BODY_LAST_CNT);
            pkt_last  = unit_last & body_last_q;
        end
        finish     = valid_q & link_ready & unit_last;
        hdr_ready  = ((state_q == ST_IDLE) & ~valid_q) | (finish & pkt_last);
        body_ready = ((state_q == ST_BODY) & ~valid_q) | (finish & ~pkt_last);
        hdr_fire   = hdr_valid & hdr_ready;
        body_fire  = body_valid & body_ready;
        link_out   = {valid_q, pkt_last, unit_last,
                      valid_q ? sr_q[SR_W-1 -: BW_PHIT] : {BW_PHIT{1'b0}}};
    end

    // Next state: shift on transfer, close the unit on finish, then reload from a new header or beat
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        has_body_d  = has_body_q;
        body_last_d = body_last_q;

        if (valid_q & link_ready) begin
            sr_d  = sr_q << BW_PHIT;
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (finish) begin
            valid_d = 1'b0;
            if (state_q == ST_HDR) begin
                state_d = has_body_q ? ST_BODY : ST_IDLE;
            end else begin
                state_d = body_last_q ? ST_IDLE : ST_BODY;
            end
        end

        if (hdr_fire) begin
            sr_d       = SR_W'(hdr_data) << (SR_W - HDR_W);
            cnt_d      = '0;
            valid_d    = 1'b1;
            has_body_d = hdr_has_body;
            state_d    = ST_HDR;
        end else if (body_fire) begin
            sr_d        = SR_W'(body_data) << (SR_W - BODY_W);
            cnt_d       = '0;
            valid_d     = 1'b1;
            body_last_d = body_last;
            state_d     = ST_BODY;
        end
    end

    // Packetizer state registers; reset abandons any partial packet immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            sr_q        <= '0;
            cnt_q       <= '0;
            has_body_q  <= 1'b0;
            body_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            has_body_q  <= has_body_d;
            body_last_q <= body_last_d;
        end
    end

`ifdef MUNOC_FNI_TX_STALL_COUNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where a phit is offered but the router holds it off
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_q & ~link_ready & (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_munoc_fni_link_packetizer.sv
// tb/tb_munoc_fni_link_packetizer.sv - self-checking bench for munoc_fni_link_packetizer
`timescale 1ns/1ps
module tb_munoc_fni_link_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hdr_valid = 1'b0;
    logic        hdr_ready;
    logic [31:0] hdr_data = '0;
    logic        hdr_has_body = 1'b0;
    logic        body_valid = 1'b0;
    logic        body_ready;
    logic [31:0] body_data = '0;
    logic        body_last = 1'b0;
    logic [10:0] link_out;
    logic        link_ready = 1'b0;
`ifdef MUNOC_FNI_TX_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    always #5 clk = ~clk;

    munoc_fni_link_packetizer #(
        .BW_PHIT(8), .NUM_HEADER_PHIT(4), .NUM_BODY_PHIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_data(hdr_data), .hdr_has_body(hdr_has_body),
        .body_valid(body_valid), .body_ready(body_ready), .body_data(body_data), .body_last(body_last),
        .link_out(link_out), .link_ready(link_ready)
`ifdef MUNOC_FNI_TX_STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hold_viol = 0;
    int stall_model = 0;

    logic [31:0] hq_data[$];
    bit          hq_hb[$];
    logic [31:0] bq_data[$];
    bit          bq_last[$];
    logic [9:0]  exp_q[$];
    logic [9:0]  obs_d[$];
    int          obs_cyc[$];
    bit          obs_hr[$];
    int          hacc_cyc[$];
    int          bacc_cyc[$];

    // Reference model: a header unit is sent MS byte first, pkt_last on its last phit if no body
    function automatic void add_header(input logic [31:0] h, input bit hb);
        hq_data.push_back(h);
        hq_hb.push_back(hb);
        for (int i = 0; i < 4; i++)
            exp_q.push_back({1'((i == 3) && !hb), 1'(i == 3), h[31-8*i -: 8]});
    endfunction

    function automatic void add_beat(input logic [31:0] d, input bit last);
        bq_data.push_back(d);
        bq_last.push_back(last);
        for (int i = 0; i < 4; i++)
            exp_q.push_back({1'((i == 3) && last), 1'(i == 3), d[31-8*i -: 8]});
    endfunction

    function automatic void clear_all();
        hq_data.delete(); hq_hb.delete(); bq_data.delete(); bq_last.delete(); exp_q.delete();
    endfunction

    // mode 0: link always ready, 1: ready toggles 1010..., 2: random ready and random offers
    task automatic run_traffic(input int mode, input int budget, input int n_target);
        int n_want;
        int c;
        bit prev_stall;
        logic [10:0] prev_out;
        bit hf, bf;
        n_want = (n_target < 0) ? exp_q.size() : n_target;
        c = 0;
        prev_stall = 1'b0;
        prev_out = '0;
        hold_viol = 0;
        obs_d.delete(); obs_cyc.delete(); obs_hr.delete(); hacc_cyc.delete(); bacc_cyc.delete();
        while (obs_d.size() < n_want && c < budget) begin
            @(negedge clk);
            hdr_valid    = (hq_data.size() > 0) && (mode != 2 || $urandom_range(3) != 0);
            hdr_data     = (hq_data.size() > 0) ? hq_data[0] : $urandom;
            hdr_has_body = (hq_hb.size() > 0) ? hq_hb[0] : 1'b0;
            body_valid   = (bq_data.size() > 0) && (mode != 2 || $urandom_range(3) != 0);
            body_data    = (bq_data.size() > 0) ? bq_data[0] : $urandom;
            body_last    = (bq_last.size() > 0) ? bq_last[0] : 1'b0;
            link_ready   = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(c % 2 == 0) : 1'($urandom_range(1));
            #1;
            if (prev_stall && link_out !== prev_out) hold_viol++;
            if (link_out[10] && link_ready) begin
                obs_d.push_back(link_out[9:0]);
                obs_cyc.push_back(cyc);
                obs_hr.push_back(hdr_ready);
            end
            if (link_out[10] && !link_ready) stall_model++;
            prev_stall = link_out[10] && !link_ready;
            prev_out = link_out;
            hf = hdr_valid && hdr_ready;
            bf = body_valid && body_ready;
            if (hf) hacc_cyc.push_back(cyc);
            if (bf) bacc_cyc.push_back(cyc);
            @(posedge clk);
            if (hf) begin void'(hq_data.pop_front()); void'(hq_hb.pop_front()); end
            if (bf) begin void'(bq_data.pop_front()); void'(bq_last.pop_front()); end
            c++;
            cyc++;
        end
        @(negedge clk);
        hdr_valid = 1'b0;
        body_valid = 1'b0;
        link_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (link_out !== 11'h000) begin errors++; $display("FAIL reset_link got %h want 000", link_out); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (hdr_ready !== 1'b1) begin errors++; $display("FAIL reset_hdr_ready got %b want 1", hdr_ready); end
        checks++; if (body_ready !== 1'b0) begin errors++; $display("FAIL reset_body_ready got %b want 0", body_ready); end
        checks++; if (link_out !== 11'h000) begin errors++; $display("FAIL reset_link_rel got %h want 000", link_out); end
`ifdef MUNOC_FNI_TX_STALL_COUNT_EN
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_count); end
`endif
    endtask

    task automatic test_hdr_only();
        clear_all();
        add_header(32'hA1B2C3D4, 1'b0);
        run_traffic(0, 50, -1);
        checks++; if (obs_d.size() !== exp_q.size()) begin errors++; $display("FAIL hdr_only_count got %0d want %0d", obs_d.size(), exp_q.size()); end
        for (int i = 0; i < obs_d.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL hdr_only_phit%0d got %h want %h", i, obs_d[i], exp_q[i]); end
        end
        if (obs_d.size() >= 4 && hacc_cyc.size() >= 1) begin
            checks++; if (obs_cyc[0] !== hacc_cyc[0] + 1) begin errors++; $display("FAIL hdr_only_latency got %0d want %0d", obs_cyc[0], hacc_cyc[0] + 1); end
            checks++; if (obs_cyc[3] - obs_cyc[0] !== 3) begin errors++; $display("FAIL hdr_only_span got %0d want 3", obs_cyc[3] - obs_cyc[0]); end
            checks++; if (obs_hr[3] !== 1'b1) begin errors++; $display("FAIL hdr_only_ready_at_last got %b want 1", obs_hr[3]); end
        end
    endtask

    task automatic test_body();
        clear_all();
        add_header(32'h11223344, 1'b1);
        add_beat(32'h55667788, 1'b0);
        add_beat(32'h99AABBCC, 1'b1);
        run_traffic(0, 60, -1);
        checks++; if (obs_d.size() !== exp_q.size()) begin errors++; $display("FAIL body_count got %0d want %0d", obs_d.size(), exp_q.size()); end
        for (int i = 0; i < obs_d.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL body_phit%0d got %h want %h", i, obs_d[i], exp_q[i]); end
        end
        if (obs_d.size() >= 12) begin
            checks++; if (obs_cyc[11] - obs_cyc[0] !== 11) begin errors++; $display("FAIL body_no_bubble got %0d want 11", obs_cyc[11] - obs_cyc[0]); end
        end
    endtask

    task automatic test_stall();
        clear_all();
        add_header(32'h11223344, 1'b1);
        add_beat(32'h55667788, 1'b0);
        add_beat(32'h99AABBCC, 1'b1);
        run_traffic(1, 100, -1);
        checks++; if (obs_d.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count_phits got %0d want %0d", obs_d.size(), exp_q.size()); end
        for (int i = 0; i < obs_d.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL stall_phit%0d got %h want %h", i, obs_d[i], exp_q[i]); end
        end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL stall_hold got %0d want 0", hold_viol); end
`ifdef MUNOC_FNI_TX_STALL_COUNT_EN
        #1;
        checks++; if (stall_count !== 16'(stall_model)) begin errors++; $display("FAIL stall_counter got %0d want %0d", stall_count, stall_model); end
`endif
    endtask

    task automatic test_back_to_back();
        clear_all();
        add_header(32'h01020304, 1'b0);
        add_header(32'h05060708, 1'b0);
        run_traffic(0, 60, -1);
        checks++; if (obs_d.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_d.size(), exp_q.size()); end
        for (int i = 0; i < obs_d.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_phit%0d got %h want %h", i, obs_d[i], exp_q[i]); end
        end
        if (obs_d.size() >= 8 && hacc_cyc.size() >= 2) begin
            checks++; if (hacc_cyc[1] !== obs_cyc[3]) begin errors++; $display("FAIL b2b_accept_cycle got %0d want %0d", hacc_cyc[1], obs_cyc[3]); end
            checks++; if (obs_cyc[7] - obs_cyc[0] !== 7) begin errors++; $display("FAIL b2b_span got %0d want 7", obs_cyc[7] - obs_cyc[0]); end
        end
    endtask

    task automatic test_body_gap();
        logic [31:0] h;
        h = 32'h5A6B7C8D;
        clear_all();
        @(negedge clk);
        hdr_valid = 1'b1; hdr_data = h; hdr_has_body = 1'b1; body_valid = 1'b0; link_ready = 1'b1;
        #1;
        checks++; if (hdr_ready !== 1'b1) begin errors++; $display("FAIL gap_hdr_ready got %b want 1", hdr_ready); end
        @(negedge clk);
        hdr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (link_out !== {1'b1, 1'b0, 1'(i == 3), h[31-8*i -: 8]}) begin
                errors++; $display("FAIL gap_hdr_phit%0d got %h want %h", i, link_out, {1'b1, 1'b0, 1'(i == 3), h[31-8*i -: 8]});
            end
            @(negedge clk);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (link_out[10] !== 1'b0) begin errors++; $display("FAIL gap_valid_c%0d got %b want 0", k, link_out[10]); end
            checks++; if (body_ready !== 1'b1) begin errors++; $display("FAIL gap_body_ready_c%0d got %b want 1", k, body_ready); end
            @(negedge clk);
        end
        add_beat(32'hE1F20314, 1'b1);
        run_traffic(0, 50, -1);
        checks++; if (obs_d.size() !== exp_q.size()) begin errors++; $display("FAIL gap_count got %0d want %0d", obs_d.size(), exp_q.size()); end
        for (int i = 0; i < obs_d.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL gap_phit%0d got %h want %h", i, obs_d[i], exp_q[i]); end
        end
        if (obs_d.size() >= 1 && bacc_cyc.size() >= 1) begin
            checks++; if (obs_cyc[0] !== bacc_cyc[0] + 1) begin errors++; $display("FAIL gap_latency got %0d want %0d", obs_cyc[0], bacc_cyc[0] + 1); end
        end
    endtask

    task automatic test_random();
        int nb;
        bit hb;
        clear_all();
        for (int p = 0; p < 8; p++) begin
            hb = 1'($urandom_range(1));
            add_header($urandom, hb);
            if (hb) begin
                nb = $urandom_range(3, 1);
                for (int b = 0; b < nb; b++) add_beat($urandom, b == nb - 1);
            end
        end
        run_traffic(2, 3000, -1);
        checks++; if (obs_d.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_d.size(), exp_q.size()); end
        for (int i = 0; i < obs_d.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL rand_phit%0d got %h want %h", i, obs_d[i], exp_q[i]); end
        end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL rand_hold got %0d want 0", hold_viol); end
`ifdef MUNOC_FNI_TX_STALL_COUNT_EN
        #1;
        checks++; if (stall_count !== 16'(stall_model)) begin errors++; $display("FAIL rand_stall got %0d want %0d", stall_count, stall_model); end
`endif
    endtask

    task automatic test_reset_mid();
        clear_all();
        add_header(32'h0F1E2D3C, 1'b1);
        add_beat(32'h4B5A6978, 1'b1);
        run_traffic(0, 50, 5);
        #1;
        checks++; if (link_out !== {1'b1, 1'b0, 1'b0, 8'h5A}) begin errors++; $display("FAIL mid_pending got %h want %h", link_out, {1'b1, 1'b0, 1'b0, 8'h5A}); end
        rst = 1'b1;
        #1;
        checks++; if (link_out !== 11'h000) begin errors++; $display("FAIL mid_async_drop got %h want 000", link_out); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (hdr_ready !== 1'b1) begin errors++; $display("FAIL mid_hdr_ready got %b want 1", hdr_ready); end
        checks++; if (body_ready !== 1'b0) begin errors++; $display("FAIL mid_body_ready got %b want 0", body_ready); end
`ifdef MUNOC_FNI_TX_STALL_COUNT_EN
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL mid_stall_reset got %0d want 0", stall_count); end
`endif
        stall_model = 0;
        clear_all();
        add_header(32'hC0FFEE42, 1'b0);
        run_traffic(0, 50, -1);
        checks++; if (obs_d.size() !== exp_q.size()) begin errors++; $display("FAIL mid_next_count got %0d want %0d", obs_d.size(), exp_q.size()); end
        for (int i = 0; i < obs_d.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL mid_next_phit%0d got %h want %h", i, obs_d[i], exp_q[i]); end
        end
        if (obs_d.size() >= 1) begin
            checks++; if (obs_d[0] !== 10'h0C0) begin errors++; $display("FAIL mid_first_phit got %h want 0c0", obs_d[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_hdr_only();
        test_body();
        test_stall();
        test_back_to_back();
        test_body_gap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
